rv_muldiv_unit: RTL and testbench

// Multi-cycle RV32M/RV64M multiply/divide unit replacing the single-cycle combinational M-extension ops in the datapath.

---
 rtl/rv_muldiv_unit_pkg.sv | 34 +++
 rtl/rv_muldiv_unit_if.sv | 32 +++
 rtl/rv_muldiv_unit_div.sv | 68 ++++++
 rtl/rv_muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_muldiv_unit_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
// - md_op_e    : RISC-V funct3 encodings of the M-extension ops
// - md_state_e : handshake FSM states of rv_muldiv_unit
package rv_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_OP_MUL    = 3'b000,
        MD_OP_MULH   = 3'b001,
        MD_OP_MULHSU = 3'b010,
        MD_OP_MULHU  = 3'b011,
        MD_OP_DIV    = 3'b100,
        MD_OP_DIVU   = 3'b101,
        MD_OP_REM    = 3'b110,
        MD_OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_S_IDLE = 2'd0,
        MD_S_MUL  = 2'd1,
        MD_S_DIV  = 2'd2,
        MD_S_DONE = 2'd3
    } md_state_e;

    // funct3[2] splits the multiply group from the divide group
    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

    // rem/remu share funct3[2:1] == 2'b11
    function automatic logic op_is_rem(input md_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Request/response/flush bundle between the datapath and rv_muldiv_unit.
// master: datapath side (issues requests, consumes responses, flushes)
// slave : unit side
interface rv_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             MD_req_valid;
    logic             MD_req_ready;
    logic [2:0]       MD_req_op;
    logic [XLEN-1:0]  MD_req_a;
    logic [XLEN-1:0]  MD_req_b;
    logic [TAG_W-1:0] MD_req_tag;
    logic             MD_flush;
    logic             MD_resp_valid;
    logic             MD_resp_ready;
    logic [XLEN-1:0]  MD_resp_data;
    logic [TAG_W-1:0] MD_resp_tag;
    logic             MD_busy;

    modport master (
        output MD_req_valid, MD_req_op, MD_req_a, MD_req_b, MD_req_tag,
               MD_flush, MD_resp_ready,
        input  MD_req_ready, MD_resp_valid, MD_resp_data, MD_resp_tag, MD_busy
    );

    modport slave (
        input  MD_req_valid, MD_req_op, MD_req_a, MD_req_b, MD_req_tag,
               MD_flush, MD_resp_ready,
        output MD_req_ready, MD_resp_valid, MD_resp_data, MD_resp_tag, MD_busy
    );
endinterface

// File: rtl/rv_muldiv_unit_div.sv
// rv_div_iter: restoring radix-2 divider on unsigned magnitudes.
// One quotient bit per cycle, MSB first, XLEN cycles after start.
// Ports:
//   SYS_clk, SYS_reset_n : clock / async active-low reset
//   start                : load dividend/divisor, begin iterating next edge
//   abort                : drop an op in flight
//   dividend, divisor    : unsigned magnitudes
//   done                 : high during the last iteration cycle
//   quot, rem            : result of the iteration taking place this cycle
//                          (final quotient/remainder while done is high)
module rv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);
    localparam int              CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  quo_q;   // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;

    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  diff;
    logic             take;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign take   = rem_sh >= {1'b0, dvs_q};
    // Only taken when rem_sh >= divisor, so the result fits in XLEN bits
    // and the low bits of the subtraction are exact.
    assign diff   = rem_sh[XLEN-1:0] - dvs_q;
    assign quot   = {quo_q[XLEN-2:0], take};
    assign rem    = take ? diff : rem_sh[XLEN-1:0];
    assign done   = run_q && (cnt_q == LAST);

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (abort) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            quo_q <= quot;
            rem_q <= rem;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit.
// One op accepted in IDLE via valid/ready, result + tag returned via
// valid/ready. Multiply is shift-add on magnitudes (or single-cycle when
// MUL_ITERATIVE=0); divide uses rv_div_iter. Divide-by-zero and signed
// overflow finish without iterating. MD_flush abandons any op.
// Ports:
//   SYS_clk, SYS_reset_n : clock / async active-low reset
//   md (slave)           : request, response, flush and busy signals
module rv_muldiv_unit
    import rv_muldiv_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit MUL_ITERATIVE = 1'b1,
    parameter int TAG_W         = 5
) (
    input  logic            SYS_clk,
    input  logic            SYS_reset_n,
    rv_muldiv_unit_if.slave md
);
    localparam int               CNT_W   = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e        state_q, state_d;
    md_op_e           op;
    logic             req_ready, accept;

    // request decode
    logic             a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             is_div_d, is_rem_d, res_neg_d, sel_hi_d;
    logic             b_zero, ovf, quick;
    logic [2*XLEN-1:0] comb_prod;
    logic [XLEN-1:0]  quick_res;

    // iteration state
    logic [2*XLEN-1:0] prod_q;   // {partial sum, remaining multiplier bits}
    logic [XLEN-1:0]  mcand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             res_neg_q, sel_hi_q, is_rem_q;
    logic [XLEN-1:0]  data_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN:0]    mul_sum;
    logic [2*XLEN-1:0] prod_step;

    logic             div_start, div_done;
    logic [XLEN-1:0]  div_quot, div_rem, div_val;

    function automatic logic [XLEN-1:0] mul_result(input logic [2*XLEN-1:0] p,
                                                   input logic neg, input logic hi);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return hi ? s[2*XLEN-1:XLEN] : s[XLEN-1:0];
    endfunction

    assign op        = md_op_e'(md.MD_req_op);
    assign req_ready = (state_q == MD_S_IDLE) && !md.MD_flush;
    assign accept    = md.MD_req_valid && req_ready;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        unique case (op)
            MD_OP_MULH, MD_OP_DIV, MD_OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
            MD_OP_MULHSU:                     a_sgn = 1'b1;
            default:                          ;
        endcase
    end

    assign a_neg     = a_sgn & md.MD_req_a[XLEN-1];
    assign b_neg     = b_sgn & md.MD_req_b[XLEN-1];
    assign a_mag     = a_neg ? -md.MD_req_a : md.MD_req_a;
    assign b_mag     = b_neg ? -md.MD_req_b : md.MD_req_b;
    assign is_div_d  = op_is_div(op);
    assign is_rem_d  = op_is_rem(op);
    // remainder takes the dividend's sign; everything else sign(a)^sign(b)
    assign res_neg_d = is_rem_d ? a_neg : (a_neg ^ b_neg);
    assign sel_hi_d  = !is_div_d && (op != MD_OP_MUL);
    assign b_zero    = (md.MD_req_b == '0);
    assign ovf       = a_sgn && is_div_d && (md.MD_req_a == MIN_INT) && (md.MD_req_b == '1);
    assign quick     = is_div_d ? (b_zero || ovf) : !MUL_ITERATIVE;

    if (MUL_ITERATIVE) begin : g_mul_iter
        assign comb_prod = '0;
    end else begin : g_mul_fast
        assign comb_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    end

    // Results that need no iteration; for divide ops only used when quick.
    always_comb begin
        quick_res = mul_result(comb_prod, res_neg_d, sel_hi_d);
        if (is_div_d) begin
            if (b_zero) quick_res = is_rem_d ? md.MD_req_a : '1;
            else        quick_res = is_rem_d ? '0 : MIN_INT;
        end
    end

    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step = {mul_sum, prod_q[XLEN-1:1]};

    assign div_start = accept && is_div_d && !quick;
    assign div_val   = is_rem_q ? div_rem : div_quot;

    rv_div_iter #(.XLEN(XLEN)) u_div (
        .SYS_clk     (SYS_clk),
        .SYS_reset_n (SYS_reset_n),
        .start       (div_start),
        .abort       (md.MD_flush),
        .dividend    (a_mag),
        .divisor     (b_mag),
        .done        (div_done),
        .quot        (div_quot),
        .rem         (div_rem)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) state_q <= MD_S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (md.MD_flush) begin
            state_d = MD_S_IDLE;
        end else begin
            unique case (state_q)
                MD_S_IDLE: if (accept)
                               state_d = quick ? MD_S_DONE : (is_div_d ? MD_S_DIV : MD_S_MUL);
                MD_S_MUL:  if (cnt_q == LAST)   state_d = MD_S_DONE;
                MD_S_DIV:  if (div_done)        state_d = MD_S_DONE;
                MD_S_DONE: if (md.MD_resp_ready) state_d = MD_S_IDLE;
                default:                        state_d = MD_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            prod_q    <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            res_neg_q <= 1'b0;
            sel_hi_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            prod_q    <= {{XLEN{1'b0}}, b_mag};
            mcand_q   <= a_mag;
            cnt_q     <= '0;
            res_neg_q <= res_neg_d;
            sel_hi_q  <= sel_hi_d;
            is_rem_q  <= is_rem_d;
            tag_q     <= md.MD_req_tag;
            if (quick) data_q <= quick_res;
        end else if (state_q == MD_S_MUL) begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + 1'b1;
            // sign fix-up folded into the last iteration so DONE has the result
            if (cnt_q == LAST) data_q <= mul_result(prod_step, res_neg_q, sel_hi_q);
        end else if (state_q == MD_S_DIV && div_done) begin
            data_q <= res_neg_q ? -div_val : div_val;
        end
    end

    assign md.MD_req_ready  = req_ready;
    assign md.MD_resp_valid = (state_q == MD_S_DONE);
    assign md.MD_resp_data  = data_q;
    assign md.MD_resp_tag   = tag_q;
    assign md.MD_busy       = (state_q != MD_S_IDLE);
endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;
    import rv_muldiv_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) m ();
    rv_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) f ();

    rv_muldiv_unit #(.XLEN(XLEN), .MUL_ITERATIVE(1'b1), .TAG_W(TAG_W)) dut (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .md(m.slave));
    rv_muldiv_unit #(.XLEN(XLEN), .MUL_ITERATIVE(1'b0), .TAG_W(TAG_W)) dut_fast (
        .SYS_clk(clk), .SYS_reset_n(rst_n), .md(f.slave));

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] data; logic [4:0] tag; } exp_t;
    exp_t expq[$];

    // Reference: RISC-V M semantics from plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = '0;
        case (op)
            MD_OP_MUL:    begin p = ua * ub;                    model = p[31:0];  end
            MD_OP_MULH:   begin p = 64'(sa * sb);               model = p[63:32]; end
            MD_OP_MULHSU: begin p = 64'(sa * longint'(ub));     model = p[63:32]; end
            MD_OP_MULHU:  begin p = ua * ub;                    model = p[63:32]; end
            MD_OP_DIV:    model = (b == 0) ? 32'hFFFF_FFFF :
                                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            MD_OP_DIVU:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_OP_REM:    model = (b == 0) ? a :
                                  (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            MD_OP_REMU:   model = (b == 0) ? a : a % b;
            default:      model = '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every cycle a response is presented it must match the oldest outstanding op.
    always @(negedge clk) begin
        if (rst_n && m.MD_resp_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_resp", 32'(m.MD_resp_valid), 32'd0);
            end else begin
                chk("model_data", m.MD_resp_data, expq[0].data);
                chk("model_tag", 32'(m.MD_resp_tag), 32'(expq[0].tag));
            end
        end
        if (m.MD_flush) expq.delete();
        else if (rst_n && m.MD_resp_valid && m.MD_resp_ready && expq.size() > 0)
            void'(expq.pop_front());
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n;
        exp_t e;
        n = 0;
        m.MD_req_valid = 1'b1;
        m.MD_req_op    = op;
        m.MD_req_a     = a;
        m.MD_req_b     = b;
        m.MD_req_tag   = tag;
        @(negedge clk);
        while (!m.MD_req_ready && n < 50) begin n++; @(negedge clk); end
        chk("req_ready", 32'(m.MD_req_ready), 32'd1);
        e.data = model(op, a, b);
        e.tag  = tag;
        expq.push_back(e);
        @(posedge clk); #1;
        m.MD_req_valid = 1'b0;
    endtask

    // lat = number of falling edges after the accepting edge until resp_valid
    task automatic wait_resp(output int lat, output logic [31:0] data, output logic [4:0] tag);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!m.MD_resp_valid && lat < 100);
        data = m.MD_resp_data;
        tag  = m.MD_resp_tag;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input int exp_lat);
        int          lat;
        logic [31:0] d;
        logic [4:0]  t;
        issue(op, a, b, tag);
        wait_resp(lat, d, t);
        chk({name, "_data"}, d, exp);
        chk({name, "_tag"}, 32'(t), 32'(tag));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        chk({name, "_idle"}, 32'(m.MD_busy), 32'd0);
    endtask

    task automatic fast_op(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        f.MD_req_valid = 1'b1;
        f.MD_req_op    = op;
        f.MD_req_a     = a;
        f.MD_req_b     = b;
        f.MD_req_tag   = 5'd17;
        @(negedge clk);
        chk({name, "_rdy"}, 32'(f.MD_req_ready), 32'd1);
        @(posedge clk); #1;
        f.MD_req_valid = 1'b0;
        @(negedge clk);
        chk({name, "_vld"}, 32'(f.MD_resp_valid), 32'd1);
        chk({name, "_data"}, f.MD_resp_data, exp);
        chk({name, "_model"}, f.MD_resp_data, model(op, a, b));
        chk({name, "_tag"}, 32'(f.MD_resp_tag), 32'd17);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat, seen;
        logic [31:0] d;
        logic [4:0]  t;
        m.MD_req_valid = 1'b0; m.MD_req_op = '0; m.MD_req_a = '0; m.MD_req_b = '0;
        m.MD_req_tag = '0; m.MD_flush = 1'b0; m.MD_resp_ready = 1'b1;
        f.MD_req_valid = 1'b0; f.MD_req_op = '0; f.MD_req_a = '0; f.MD_req_b = '0;
        f.MD_req_tag = '0; f.MD_flush = 1'b0; f.MD_resp_ready = 1'b1;

        repeat (2) @(posedge clk); #1;
        chk("rst_valid", 32'(m.MD_resp_valid), 32'd0);
        chk("rst_data", m.MD_resp_data, 32'd0);
        chk("rst_tag", 32'(m.MD_resp_tag), 32'd0);
        chk("rst_busy", 32'(m.MD_busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(m.MD_req_ready), 32'd1);

        // iterative ops: XLEN iterations, response seen in cycle T+33
        run_op("mul",      MD_OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 33);
        run_op("mulh_min", MD_OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd12, 32'h4000_0000, 33);
        run_op("mulhsu",   MD_OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, 33);
        run_op("mulhu",    MD_OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 33);
        run_op("mulh_neg", MD_OP_MULH,   32'hFFFF_FFF9,  32'd3,         5'd15, 32'hFFFF_FFFF, 33);
        run_op("mulhu_2p", MD_OP_MULHU,  32'h0001_0000,  32'h0001_0000, 5'd16, 32'd1,         33);
        run_op("div_neg",  MD_OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd1,  32'hFFFF_FFFD, 33);
        run_op("rem_neg",  MD_OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd2,  32'hFFFF_FFFF, 33);
        run_op("div_nb",   MD_OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd3,  32'hFFFF_FFFD, 33);
        run_op("rem_nb",   MD_OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd4,  32'd1,         33);
        run_op("divu",     MD_OP_DIVU,   32'd100,        32'd7,         5'd5,  32'd14,        33);
        run_op("remu",     MD_OP_REMU,   32'd100,        32'd7,         5'd6,  32'd2,         33);
        run_op("divu_min", MD_OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 5'd7,  32'd0,         33);
        // corner cases: no iteration, response in cycle T+1
        run_op("div_z",    MD_OP_DIV,    32'd5,          32'd0,         5'd21, 32'hFFFF_FFFF, 1);
        run_op("rem_z",    MD_OP_REM,    32'd5,          32'd0,         5'd22, 32'd5,         1);
        run_op("divu_z",   MD_OP_DIVU,   32'd5,          32'd0,         5'd23, 32'hFFFF_FFFF, 1);
        run_op("remu_z",   MD_OP_REMU,   32'd5,          32'd0,         5'd24, 32'd5,         1);
        run_op("div_ovf",  MD_OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd25, 32'h8000_0000, 1);
        run_op("rem_ovf",  MD_OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd26, 32'd0,         1);

        // back-pressure: response held for 10 cycles
        m.MD_resp_ready = 1'b0;
        issue(MD_OP_DIVU, 32'd100, 32'd7, 5'd9);
        wait_resp(lat, d, t);
        chk("stall_lat", 32'(lat), 32'd33);
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", 32'(m.MD_resp_valid), 32'd1);
            chk("stall_data", m.MD_resp_data, 32'd14);
            chk("stall_tag", 32'(m.MD_resp_tag), 32'd9);
            chk("stall_req_ready", 32'(m.MD_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        m.MD_resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_busy", 32'(m.MD_busy), 32'd0);
        run_op("after_stall", MD_OP_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 33);

        // flush during divide at T+10: no response ever
        issue(MD_OP_DIV, 32'd1000, 32'd3, 5'd3);
        repeat (9) @(posedge clk); #1;
        m.MD_flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(m.MD_req_ready), 32'd0);
        @(posedge clk); #1;
        m.MD_flush = 1'b0;
        chk("flush_busy", 32'(m.MD_busy), 32'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (m.MD_resp_valid) seen++; end
        chk("flush_no_resp", 32'(seen), 32'd0);

        // flush while idle blocks a same-cycle request
        @(posedge clk); #1;
        m.MD_flush = 1'b1;
        m.MD_req_valid = 1'b1; m.MD_req_op = MD_OP_MUL; m.MD_req_a = 32'd3; m.MD_req_b = 32'd3;
        @(negedge clk);
        chk("flush_idle_ready", 32'(m.MD_req_ready), 32'd0);
        @(posedge clk); #1;
        m.MD_flush = 1'b0;
        m.MD_req_valid = 1'b0;
        chk("flush_idle_noacc", 32'(m.MD_busy), 32'd0);

        // flush in DONE drops the pending response
        m.MD_resp_ready = 1'b0;
        issue(MD_OP_DIV, 32'd5, 32'd0, 5'd30);
        wait_resp(lat, d, t);
        chk("fdone_lat", 32'(lat), 32'd1);
        @(posedge clk); #1;
        m.MD_flush = 1'b1;
        @(posedge clk); #1;
        m.MD_flush = 1'b0;
        m.MD_resp_ready = 1'b1;
        chk("fdone_valid", 32'(m.MD_resp_valid), 32'd0);
        chk("fdone_busy", 32'(m.MD_busy), 32'd0);

        // async reset mid-multiply
        issue(MD_OP_MUL, 32'd7, 32'd3, 5'd4);
        repeat (4) @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(m.MD_resp_valid), 32'd0);
        chk("arst_data", m.MD_resp_data, 32'd0);
        chk("arst_tag", 32'(m.MD_resp_tag), 32'd0);
        chk("arst_busy", 32'(m.MD_busy), 32'd0);
        expq.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_req_ready", 32'(m.MD_req_ready), 32'd1);
        run_op("after_rst", MD_OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);

        // single-cycle multiplier build
        fast_op("fast_mul",    MD_OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        fast_op("fast_mulh",   MD_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        fast_op("fast_mulhsu", MD_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        fast_op("fast_mulhu",  MD_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
